simon_round_sequencer: RTL and testbench

Iterative SIMON block-cipher engine. It sequences a single-round datapath over the configured round count, pulling one pre-expanded round key per round through a key handshake. The datapath is built from the team's parameterized shifters: rotl(v,n) = (v << n) | (v >> (WORD_SIZE-n)). It sits between the block-level input/output buffers and the key-schedule memory.

---
 rtl/simon_round_sequencer.sv | 139 +++++++++++++
 tb/tb_simon_round_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_round_sequencer.sv
// Iterative SIMON engine: one round per accepted key word, ROUNDS rounds per block.
// Optional decryption (decrypt port, reversed key order, swapped I/O) under SIMON_DECRYPT_EN.
module simon_round_sequencer #(
    parameter int WORD_SIZE = 64,
    parameter int ROUNDS    = 68
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] pt_x,
    input  logic [WORD_SIZE-1:0] pt_y,
`ifdef SIMON_DECRYPT_EN
    input  logic                 decrypt,
`endif
    output logic [6:0]           key_idx,
    output logic                 key_ready,
    input  logic                 key_valid,
    input  logic [WORD_SIZE-1:0] key_word,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] ct_x,
    output logic [WORD_SIZE-1:0] ct_y,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);

    state_t               state;
    state_t               state_next;
    logic [WORD_SIZE-1:0] x;
    logic [WORD_SIZE-1:0] y;
    logic [WORD_SIZE-1:0] f;
    logic [WORD_SIZE-1:0] x_round;
    logic [6:0]           rnd;
    logic                 dir_dec;
    logic                 load_dec;
    logic                 accept;
    logic                 step;

    function automatic logic [WORD_SIZE-1:0] rotl(input logic [WORD_SIZE-1:0] v,
                                                  input int unsigned n);
        int unsigned s;
        s = n % WORD_SIZE;
        if (s == 0) return v;
        return (v << s) | (v >> (WORD_SIZE - s));
    endfunction

    assign accept = (state == IDLE) && in_valid;
    assign step   = (state == RUN) && key_valid;

    always_comb begin
        f       = (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
        x_round = y ^ f ^ key_word;
    end

`ifdef SIMON_DECRYPT_EN
    assign load_dec = decrypt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_dec <= 1'b0;
        end else if (accept) begin
            dir_dec <= decrypt;
        end
    end
`else
    assign load_dec = 1'b0;
    assign dir_dec  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        key_ready  = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                key_ready = 1'b1;
                if (key_valid && (rnd == LAST_RND)) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_comb begin
        key_idx = '0;
        if (state == RUN) key_idx = dir_dec ? (LAST_RND - rnd) : rnd;
    end

    // ct_* are captured on the final round so they stay frozen through DONE;
    // decryption runs on swapped halves and swaps them back on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            rnd  <= '0;
            ct_x <= '0;
            ct_y <= '0;
        end else if (accept) begin
            x   <= load_dec ? pt_y : pt_x;
            y   <= load_dec ? pt_x : pt_y;
            rnd <= '0;
        end else if (step) begin
            x   <= x_round;
            y   <= x;
            rnd <= rnd + 7'd1;
            if (rnd == LAST_RND) begin
                ct_x <= dir_dec ? x : x_round;
                ct_y <= dir_dec ? x_round : x;
            end
        end
    end

endmodule

// File: tb/tb_simon_round_sequencer.sv
// Scoreboard bench for simon_round_sequencer: SIMON32/64 and SIMON128/128 instances,
// round keys expanded in the bench; decrypt checks built when SIMON_DECRYPT_EN is defined.
module tb_simon_round_sequencer;

    localparam int W  = 16;
    localparam int R  = 32;
    localparam int W2 = 64;
    localparam int R2 = 68;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          a_in_valid, a_in_ready, a_key_ready, a_key_valid, a_out_valid, a_out_ready, a_busy;
    logic          a_decrypt;
    logic [W-1:0]  a_pt_x, a_pt_y, a_key_word, a_ct_x, a_ct_y;
    logic [6:0]    a_key_idx;

    logic          b_in_valid, b_in_ready, b_key_ready, b_key_valid, b_out_valid, b_out_ready, b_busy;
    logic          b_decrypt;
    logic [W2-1:0] b_pt_x, b_pt_y, b_key_word, b_ct_x, b_ct_y;
    logic [6:0]    b_key_idx;

    logic [63:0]   rk16 [128];
    logic [63:0]   rk64 [128];
    logic [127:0]  sb_q [$];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign a_key_word = rk16[a_key_idx][15:0];
    assign b_key_word = rk64[b_key_idx];

    simon_round_sequencer #(.WORD_SIZE(W), .ROUNDS(R)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .pt_x(a_pt_x), .pt_y(a_pt_y),
`ifdef SIMON_DECRYPT_EN
        .decrypt(a_decrypt),
`endif
        .key_idx(a_key_idx), .key_ready(a_key_ready),
        .key_valid(a_key_valid), .key_word(a_key_word),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .ct_x(a_ct_x), .ct_y(a_ct_y), .busy(a_busy)
    );

    simon_round_sequencer #(.WORD_SIZE(W2), .ROUNDS(R2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .pt_x(b_pt_x), .pt_y(b_pt_y),
`ifdef SIMON_DECRYPT_EN
        .decrypt(b_decrypt),
`endif
        .key_idx(b_key_idx), .key_ready(b_key_ready),
        .key_valid(b_key_valid), .key_word(b_key_word),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .ct_x(b_ct_x), .ct_y(b_ct_y), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wmask(input int n);
        return (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [63:0] rol(input logic [63:0] v, input int s, input int n);
        int sh;
        sh = s % n;
        if (sh == 0) return v & wmask(n);
        return ((v << sh) | ((v & wmask(n)) >> (n - sh))) & wmask(n);
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int s, input int n);
        return rol(v, n - (s % n), n);
    endfunction

    function automatic logic [63:0] fr(input logic [63:0] v, input int n);
        return (rol(v, 1, n) & rol(v, 8, n)) ^ rol(v, 2, n);
    endfunction

    // Reference cipher: returns {ct_x, ct_y}, each zero-extended to 64 bits.
    function automatic logic [127:0] model(input logic [63:0] px, input logic [63:0] py,
                                           input int n, input int rounds,
                                           input bit dec, input bit big);
        logic [63:0] x, y, t, k;
        int idx;
        x = dec ? py : px;
        y = dec ? px : py;
        for (int i = 0; i < rounds; i++) begin
            idx = dec ? (rounds - 1 - i) : i;
            k = big ? rk64[idx] : rk16[idx];
            t = x;
            x = (y ^ fr(x, n) ^ k) & wmask(n);
            y = t;
        end
        return dec ? {y, x} : {x, y};
    endfunction

    task automatic key_schedule();
        logic [61:0] z0;
        logic [61:0] z2;
        logic [63:0] tmp;
        z0 = 62'b01100111000011010100100010111110110011100001101010010001011111;
        z2 = 62'b11001101101001111110001000010100011001001011000000111011110101;
        for (int i = 0; i < 128; i++) begin
            rk16[i] = '0;
            rk64[i] = '0;
        end
        rk16[0] = 64'h0100;
        rk16[1] = 64'h0908;
        rk16[2] = 64'h1110;
        rk16[3] = 64'h1918;
        for (int i = 4; i < R; i++) begin
            tmp = ror(rk16[i-1], 3, 16) ^ rk16[i-3];
            tmp = tmp ^ ror(tmp, 1, 16);
            rk16[i] = (~rk16[i-4] ^ tmp ^ 64'(z0[(i-4) % 62]) ^ 64'd3) & 64'hFFFF;
        end
        rk64[0] = 64'h0706050403020100;
        rk64[1] = 64'h0f0e0d0c0b0a0908;
        for (int i = 2; i < R2; i++) begin
            tmp = ror(rk64[i-1], 3, 64);
            tmp = tmp ^ ror(tmp, 1, 64);
            rk64[i] = ~rk64[i-2] ^ tmp ^ 64'(z2[(i-2) % 62]) ^ 64'd3;
        end
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, " in_ready"},  128'(a_in_ready),  128'(1));
        check({tag, " key_ready"}, 128'(a_key_ready), 128'(0));
        check({tag, " key_idx"},   128'(a_key_idx),   128'(0));
        check({tag, " out_valid"}, 128'(a_out_valid), 128'(0));
        check({tag, " ct"},        {64'(a_ct_x), 64'(a_ct_y)}, 128'(0));
        check({tag, " busy"},      128'(a_busy),      128'(0));
    endtask

    // Drive one 16-bit block; abort_at >= 0 asserts reset after that many rounds.
    task automatic run_a(input logic [15:0] px, input logic [15:0] py, input bit dec,
                         input bit stall, input int abort_at, input int hold,
                         input logic [127:0] exp, input string tag);
        int n;
        int waitc;
        int exp_idx;
        int lat;
        logic [127:0] want;
        logic [127:0] held;
        waitc = 0;
        while (!a_in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, " in_ready"}, 128'(a_in_ready), 128'(1));
        a_in_valid = 1'b1;
        a_pt_x     = px;
        a_pt_y     = py;
        a_decrypt  = dec;
        sb_q.push_back(exp);
        @(negedge clk);
        a_in_valid = 1'b0;
        a_pt_x     = 16'($urandom);
        a_pt_y     = 16'($urandom);
        a_decrypt  = ~dec;
        n = 1;
        exp_idx = 0;
        while (n < 400 && !a_out_valid) begin
            if (a_key_ready !== 1'b1 || a_key_idx !== 7'(dec ? (R - 1 - exp_idx) : exp_idx)) begin
                check({tag, " key_ready"}, 128'(a_key_ready), 128'(1));
                check({tag, " key_idx"}, 128'(a_key_idx), 128'(dec ? (R - 1 - exp_idx) : exp_idx));
            end
            if (abort_at >= 0 && exp_idx == abort_at) begin
                a_key_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check_a_reset({tag, " abort"});
                void'(sb_q.pop_back());
                @(negedge clk);
                rst_n = 1'b1;
                check({tag, " abort no output"}, 128'(a_out_valid), 128'(0));
                return;
            end
            a_key_valid = stall ? (n % 2 == 0) : 1'b1;
            if (a_key_valid) exp_idx++;
            @(negedge clk);
            n++;
        end
        a_key_valid = 1'b1;
        if (!a_out_valid) begin
            check({tag, " timeout"}, 128'(0), 128'(1));
            return;
        end
        lat = stall ? (2 * R + 1) : (R + 1);
        check({tag, " latency"}, 128'(n), 128'(lat));
        check({tag, " rounds"}, 128'(exp_idx), 128'(R));
        check({tag, " key_ready done"}, 128'(a_key_ready), 128'(0));
        want = sb_q.pop_front();
        held = {64'(a_ct_x), 64'(a_ct_y)};
        check({tag, " ct"}, held, want);
        for (int h = 0; h < hold; h++) begin
            a_out_ready = 1'b0;
            a_in_valid  = h[0];
            a_pt_x      = 16'($urandom);
            @(negedge clk);
            check({tag, " hold out_valid"}, 128'(a_out_valid), 128'(1));
            check({tag, " hold ct"}, {64'(a_ct_x), 64'(a_ct_y)}, want);
            check({tag, " hold in_ready"}, 128'(a_in_ready), 128'(0));
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        check({tag, " release out_valid"}, 128'(a_out_valid), 128'(0));
        check({tag, " release in_ready"},  128'(a_in_ready),  128'(1));
        check({tag, " release busy"},      128'(a_busy),      128'(0));
    endtask

    task automatic run_b(input logic [63:0] px, input logic [63:0] py,
                         input logic [127:0] exp, input string tag);
        int n;
        b_in_valid  = 1'b1;
        b_pt_x      = px;
        b_pt_y      = py;
        b_key_valid = 1'b1;
        b_out_ready = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        b_in_valid = 1'b0;
        n = 1;
        while (n < 400 && !b_out_valid) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 128'(n), 128'(R2 + 1));
        check({tag, " ct"}, {b_ct_x, b_ct_y}, sb_q.pop_front());
        @(negedge clk);
        b_out_ready = 1'b0;
        check({tag, " in_ready"}, 128'(b_in_ready), 128'(1));
    endtask

    initial begin
        logic [127:0] e;
        logic [15:0]  rx, ry;
        a_in_valid = 1'b0; a_pt_x = '0; a_pt_y = '0; a_decrypt = 1'b0;
        a_key_valid = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_pt_x = '0; b_pt_y = '0; b_decrypt = 1'b0;
        b_key_valid = 1'b0; b_out_ready = 1'b0;
        key_schedule();
        #23;
        check_a_reset("reset");
        check("reset b busy", 128'(b_busy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_a(16'h6565, 16'h6877, 1'b0, 1'b0, -1, 0, {64'hC69B, 64'hE9BB}, "enc");
        run_a(16'h6565, 16'h6877, 1'b0, 1'b1, -1, 0, {64'hC69B, 64'hE9BB}, "stall");
        run_a(16'h6565, 16'h6877, 1'b0, 1'b0, -1, 10, {64'hC69B, 64'hE9BB}, "hold");
        run_a(16'h6565, 16'h6877, 1'b0, 1'b0, 12, 0, {64'hC69B, 64'hE9BB}, "abort");
        run_a(16'h6565, 16'h6877, 1'b0, 1'b0, -1, 0, {64'hC69B, 64'hE9BB}, "post_abort");

        for (int i = 0; i < 8; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            run_a(rx, ry, 1'b0, i[0], -1, 0, model(64'(rx), 64'(ry), W, R, 1'b0, 1'b0), "rand_enc");
        end

`ifdef SIMON_DECRYPT_EN
        run_a(16'hC69B, 16'hE9BB, 1'b1, 1'b0, -1, 0, {64'h6565, 64'h6877}, "dec");
        for (int i = 0; i < 100; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            e = model(64'(rx), 64'(ry), W, R, 1'b0, 1'b0);
            run_a(rx, ry, 1'b0, 1'b0, -1, 0, e, "rt_enc");
            run_a(e[79:64], e[15:0], 1'b1, i[0], -1, 0, {64'(rx), 64'(ry)}, "rt_dec");
        end
`endif

        run_b(64'h6373656420737265, 64'h6c6c657661727420,
              {64'h49681b1e1e54fe3f, 64'h65aa832af84e0bbc}, "simon128");

        check("scoreboard empty", 128'(sb_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
